uart_tx_frame: RTL

- UART transmitter; the transmit-side counterpart of the UART-RX datapath.
- Accepts a parallel byte with a one-cycle valid strobe and serializes it onto TX_OUT as: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
- Bit timing comes from the same oversampled CLK and prescaler used by the receiver: each bit is held for prescaler CLK cycles.
- Sits between the system-side register interface and the serial line pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/tx_bit_timer.sv | 70 +++++++
 rtl/uart_tx_frame.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions.
// FSM encoding, parity selectors and timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int MIN_PRESCALE = 2;

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit edge counter and data-bit counter for the UART transmitter.
// Latches the clamped prescaler when a frame is loaded.
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic                      run_i,
  input  logic                      data_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      bit_done_o,
  output logic                      last_bit_o
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESCALE_WIDTH-1:0] P_MIN =
    PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE =
    PRESCALE_WIDTH'(1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);

  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [PRESCALE_WIDTH-1:0] p_eff;
  logic [BW-1:0]             bit_q, bit_d;

  assign p_eff = (prescale_i < P_MIN) ? P_MIN
                                      : prescale_i;

  assign bit_done_o = run_i && (edge_q == p_q - P_ONE);
  assign last_bit_o = (bit_q == LAST);

  always_comb begin
    p_d    = p_q;
    edge_d = edge_q;
    bit_d  = bit_q;
    if (load_i) begin
      p_d    = p_eff;
      edge_d = '0;
      bit_d  = '0;
    end else if (bit_done_o) begin
      edge_d = '0;
      if (data_i) begin
        bit_d = last_bit_o ? '0 : bit_q + B_ONE;
      end
    end else if (run_i) begin
      edge_d = edge_q + P_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q    <= P_MIN;
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      p_q    <= p_d;
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// All line outputs come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescaler,
  output logic                      TX_OUT,
  output logic                      Busy
);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  par_q;
  logic                  par_en_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  accept;
  logic                  bit_done;
  logic                  last_bit;

  assign accept    = Data_Valid && !busy_q;
  assign shift_nxt = shift_q >> 1;
  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;

  tx_bit_timer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (accept),
    .run_i      (busy_q),
    .data_i     (state_q == DATA),
    .prescale_i (prescaler),
    .bit_done_o (bit_done),
    .last_bit_o (last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q  <= P_DATA;
            par_q    <= (PAR_TYP == PAR_ODD) ? ~^P_DATA
                                             : ^P_DATA;
            par_en_q <= PAR_EN;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (!last_bit) begin
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
            end else if (par_en_q) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= IDLE_LEVEL;
              state_q <= STOP;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx_q    <= IDLE_LEVEL;
            state_q <= STOP;
          end
        end
        STOP: begin
          // Busy drops here, so a Valid seen on this edge waits one cycle.
          if (bit_done) begin
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
